// File: rtl/stack_controller.sv
// Multicycle Moore control unit for the 8-bit stack processor: fetch, decode and a
// per-opcode execute sequence, plus a debug state code and retired-instruction counter.
module stack_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  output logic             iord,
  output logic             srcA,
  output logic             srcB,
  output logic             pcSrc,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             tos,
  output logic             push,
  output logic             pop,
  output logic             mtos,
  output logic             ldA,
  output logic             ldB,
  output logic [1:0]       ALUop,
  output logic [3:0]       state,
  output logic             instrDone,
  output logic [CNT_W-1:0] instrCount
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_POPA   = 4'd3,
    S_POPB   = 4'd4,
    S_ALU    = 4'd5,
    S_PUSHR  = 4'd6,
    S_MEMRD  = 4'd7,
    S_PUSHM  = 4'd8,
    S_MEMWR  = 4'd9,
    S_JMP    = 4'd10,
    S_JZTOS  = 4'd11,
    S_JZ     = 4'd12
  } state_t;

  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_PSH = 3'b100;
  localparam logic [2:0] OP_POP = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  state_t     cur, nxt;
  logic [2:0] op_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= S_IDLE;
      op_q       <= '0;
      instrCount <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) op_q <= opcode;
      if (instrDone) instrCount <= instrCount + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    nxt = S_IDLE;
    unique case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_PSH:  nxt = S_MEMRD;
          OP_JMP:  nxt = S_JMP;
          OP_JZ:   nxt = S_JZTOS;
          default: nxt = S_POPA;
        endcase
      end
      S_POPA: begin
        if (op_q == OP_POP)      nxt = S_MEMWR;
        else if (op_q == OP_NOT) nxt = S_ALU;
        else                     nxt = S_POPB;
      end
      S_POPB:  nxt = S_ALU;
      S_ALU:   nxt = S_PUSHR;
      S_MEMRD: nxt = S_PUSHM;
      S_JZTOS: nxt = S_JZ;
      S_PUSHR, S_PUSHM, S_MEMWR, S_JMP, S_JZ: nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    iord        = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    pcSrc       = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    tos         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    mtos        = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    ALUop       = 2'b00;
    instrDone   = 1'b0;
    unique case (cur)
      S_FETCH: begin
        memRead = 1'b1;
        irWrite = 1'b1;
        pcWrite = 1'b1;
      end
      S_POPA: begin
        tos = 1'b1;
        pop = 1'b1;
        ldA = 1'b1;
      end
      S_POPB: begin
        tos = 1'b1;
        pop = 1'b1;
        ldB = 1'b1;
      end
      S_ALU: begin
        srcA  = 1'b1;
        srcB  = 1'b1;
        ALUop = op_q[1:0];
      end
      S_PUSHR: begin
        push      = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memRead = 1'b1;
      end
      S_PUSHM: begin
        mtos      = 1'b1;
        push      = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        memWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_JMP: begin
        pcSrc     = 1'b1;
        pcWrite   = 1'b1;
        instrDone = 1'b1;
      end
      // Stack top is presented without popping so the zero flag can sample it.
      S_JZTOS: tos = 1'b1;
      S_JZ: begin
        pcSrc       = 1'b1;
        pcWriteCond = 1'b1;
        instrDone   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: per-opcode state/control tables feed a
// scoreboard queue that is compared cycle by cycle, plus reset corner cases.
module tb_stack_controller;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       opcode = 3'b000;
  logic             iord, srcA, srcB, pcSrc, pcWrite, pcWriteCond, memRead, memWrite;
  logic             irWrite, tos, push, pop, mtos, ldA, ldB, instrDone;
  logic [1:0]       ALUop;
  logic [3:0]       state;
  logic [CNT_W-1:0] instrCount;

  stack_controller #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .iord(iord), .srcA(srcA), .srcB(srcB), .pcSrc(pcSrc), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .tos(tos), .push(push), .pop(pop), .mtos(mtos),
    .ldA(ldA), .ldB(ldB), .ALUop(ALUop), .state(state),
    .instrDone(instrDone), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, src_a, src_b, pc_src, pc_write, pc_write_cond;
    logic       mem_read, mem_write, ir_write, tos, push, pop, mtos, ld_a, ld_b;
    logic [1:0] alu_op;
    logic       done;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      ctrl;
  } exp_t;

  typedef struct {
    logic [2:0]      op;
    int              n;
    logic [5:0][3:0] seq;
  } vec_t;

  vec_t  vecs[8];
  exp_t  exp_q[$];
  ctrl_t act;
  int    errors = 0;
  int    checks = 0;
  int    exp_cnt = 0;

  always_comb act = {iord, srcA, srcB, pcSrc, pcWrite, pcWriteCond, memRead, memWrite,
                     irWrite, tos, push, pop, mtos, ldA, ldB, ALUop, instrDone};

  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [2:0] op);
    ctrl_t c = '0;
    case (st)
      4'd1:  begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; end
      4'd3:  begin c.tos = 1; c.pop = 1; c.ld_a = 1; end
      4'd4:  begin c.tos = 1; c.pop = 1; c.ld_b = 1; end
      4'd5:  begin c.src_a = 1; c.src_b = 1; c.alu_op = op[1:0]; end
      4'd6:  begin c.push = 1; c.done = 1; end
      4'd7:  begin c.iord = 1; c.mem_read = 1; end
      4'd8:  begin c.mtos = 1; c.push = 1; c.done = 1; end
      4'd9:  begin c.iord = 1; c.mem_write = 1; c.done = 1; end
      4'd10: begin c.pc_src = 1; c.pc_write = 1; c.done = 1; end
      4'd11: c.tos = 1;
      4'd12: begin c.pc_src = 1; c.pc_write_cond = 1; c.done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic set_vec(input int idx, input int n, input logic [3:0] s0, s1, s2, s3, s4, s5);
    vecs[idx].op     = idx[2:0];
    vecs[idx].n      = n;
    vecs[idx].seq[0] = s0;
    vecs[idx].seq[1] = s1;
    vecs[idx].seq[2] = s2;
    vecs[idx].seq[3] = s3;
    vecs[idx].seq[4] = s4;
    vecs[idx].seq[5] = s5;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic sample_and_compare(input string tag);
    exp_t e;
    logic [31:0] cnt_mod;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cnt_mod = exp_cnt % (1 << CNT_W);
    check({tag, " state"}, 32'(state), 32'(e.st));
    check({tag, " ctrl"},  32'(act),   32'(e.ctrl));
    check({tag, " count"}, 32'(instrCount), cnt_mod);
    if (e.ctrl.done) exp_cnt++;
  endtask

  // Drives one instruction, queues its expected trace, and compares ncyc cycles (0 = all).
  task automatic run_instr(input int idx, input bit chg_in_popa, input int ncyc);
    int cyc;
    opcode = vecs[idx].op;
    for (int i = 0; i < vecs[idx].n; i++)
      exp_q.push_back({vecs[idx].seq[i], exp_ctrl(vecs[idx].seq[i], vecs[idx].op)});
    cyc = (ncyc == 0) ? vecs[idx].n : ncyc;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      sample_and_compare($sformatf("op%0d cyc%0d", idx, i));
      if (chg_in_popa && state == 4'd3) opcode = 3'b110;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    set_vec(0, 6, 1, 2, 3, 4, 5, 6);
    set_vec(1, 6, 1, 2, 3, 4, 5, 6);
    set_vec(2, 6, 1, 2, 3, 4, 5, 6);
    set_vec(3, 5, 1, 2, 3, 5, 6, 0);
    set_vec(4, 4, 1, 2, 7, 8, 0, 0);
    set_vec(5, 4, 1, 2, 3, 9, 0, 0);
    set_vec(6, 3, 1, 2, 10, 0, 0, 0);
    set_vec(7, 4, 1, 2, 11, 12, 0, 0);

    // Asynchronous reset mid-cycle, observed without a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl",  32'(act),   32'd0);
    check("reset count", 32'(instrCount), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_instr(0, 1'b0, 0);  // ADD
    run_instr(3, 1'b1, 0);  // NOT, opcode changed to JMP during POPA
    run_instr(1, 1'b0, 0);  // SUB
    run_instr(2, 1'b0, 0);  // AND
    run_instr(4, 1'b0, 0);  // PUSH
    run_instr(5, 1'b0, 0);  // POP
    run_instr(6, 1'b0, 0);  // JMP
    run_instr(7, 1'b0, 0);  // JZ
    run_instr(6, 1'b0, 0);  // JMP: count now 9 mod 4 = 1

    // ADD interrupted by reset while in POPB.
    run_instr(0, 1'b0, 4);
    #1 rst = 1'b1;
    #1;
    check("midop reset state", 32'(state), 32'd0);
    check("midop reset ctrl",  32'(act),   32'd0);
    check("midop reset count", 32'(instrCount), 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check("held reset state", 32'(state), 32'd0);
    check("held reset push",  32'(push),  32'd0);
    rst = 1'b0;

    run_instr(7, 1'b0, 0);  // JZ after recovery
    run_instr(3, 1'b0, 0);  // NOT

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
